// File: rtl/tjmono_tx_emu.sv
// TJ-Mono hit transmitter emulator: hit FIFO with
// freeze bookkeeping and a 27-bit MSB-first serializer.
module tjmono_tx_emu #(
    parameter int FIFO_DEPTH  = 16,
    parameter int GRAY_ENCODE = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          HIT_WRITE,
    input  logic [5:0]                    HIT_COL,
    input  logic [8:0]                    HIT_ROW,
    input  logic [5:0]                    HIT_LE,
    input  logic [5:0]                    HIT_TE,
    input  logic                          FREEZE,
    input  logic                          READ,
    output logic                          TOKEN,
    output logic                          DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic [7:0]                    LOST_CNT,
    output logic [7:0]                    ERR_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [26:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [CW-1:0]  frozen_cnt;
    logic           read_q;
    logic           freeze_q;
    logic [26:0]    shreg;
    logic [4:0]     bitcnt;
    logic           token_q;
    logic [7:0]     lost_q;
    logic [7:0]     err_q;
    logic           load;
    logic           err_inc;
    logic           pop_en;
    logic           push_acc;
    logic           full;
    logic           empty;
    logic           read_rise;
    logic           freeze_rise;
    logic           freeze_fall;
    logic [26:0]    hit_word;

    function automatic logic [5:0] enc(input logic [5:0] x);
        if (GRAY_ENCODE == 1)
            return x ^ (x >> 1);
        else
            return x;
    endfunction

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign read_rise   = READ & ~read_q;
    assign freeze_rise = FREEZE & ~freeze_q;
    assign freeze_fall = ~FREEZE & freeze_q;
    assign pop_en      = load & ~empty;
    assign push_acc    = HIT_WRITE & (~full | pop_en);
    assign count_nxt   = count + CW'(push_acc) - CW'(pop_en);
    assign hit_word    = {HIT_COL, enc(HIT_TE), enc(HIT_LE), HIT_ROW};

    assign TOKEN      = token_q;
    assign DATA       = (state == SHIFT) & shreg[26];
    assign FIFO_COUNT = count;
    assign LOST_CNT   = lost_q;
    assign ERR_CNT    = err_q;

    // Serializer state register.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: a rise on the last shift bit chains the next word.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (read_rise) begin
                    load      = 1'b1;
                    err_inc   = empty;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (read_rise && bitcnt == 5'd0) begin
                    load    = 1'b1;
                    err_inc = empty;
                end else begin
                    err_inc = read_rise;
                    if (bitcnt == 5'd0)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hit storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push_acc)
            mem[wr_ptr] <= hit_word;
    end

    // FIFO pointers, occupancy, edge registers and counters.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frozen_cnt <= '0;
            read_q     <= 1'b0;
            freeze_q   <= 1'b0;
            token_q    <= 1'b0;
            lost_q     <= 8'd0;
            err_q      <= 8'd0;
        end else begin
            read_q   <= READ;
            freeze_q <= FREEZE;
            count    <= count_nxt;
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (freeze_fall)
                frozen_cnt <= '0;
            else if (freeze_rise)
                frozen_cnt <= count_nxt;
            else if (pop_en && frozen_cnt != '0)
                frozen_cnt <= frozen_cnt - 1'b1;
            if (FREEZE)
                token_q <= freeze_rise ? (count != '0)
                                       : (frozen_cnt != '0);
            else
                token_q <= (count != '0);
            if (HIT_WRITE && !push_acc && lost_q != 8'hFF)
                lost_q <= lost_q + 8'd1;
            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    // Shift register: load a word or move one bit toward DATA.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shreg  <= '0;
            bitcnt <= 5'd0;
        end else if (load) begin
            shreg  <= empty ? 27'd0 : mem[rd_ptr];
            bitcnt <= 5'd26;
        end else if (state == SHIFT) begin
            shreg  <= {shreg[25:0], 1'b0};
            bitcnt <= bitcnt - 5'd1;
        end
    end

endmodule

// File: tb/tb_tjmono_tx_emu.sv
// Self-checking bench for tjmono_tx_emu using a
// queue-based model of the hit FIFO and readout.
module tb_tjmono_tx_emu;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          RST_N;
    logic          HIT_WRITE;
    logic [5:0]    HIT_COL;
    logic [8:0]    HIT_ROW;
    logic [5:0]    HIT_LE;
    logic [5:0]    HIT_TE;
    logic          FREEZE;
    logic          READ;
    logic          TOKEN;
    logic          DATA;
    logic [CW-1:0] FIFO_COUNT;
    logic [7:0]    LOST_CNT;
    logic [7:0]    ERR_CNT;

    int checks;
    int failures;

    logic [26:0] q[$];
    int          lost_m;
    int          err_m;
    int          frozen_m;
    bit          frz_m;

    tjmono_tx_emu #(
        .FIFO_DEPTH (DEPTH),
        .GRAY_ENCODE(1)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .HIT_WRITE (HIT_WRITE),
        .HIT_COL   (HIT_COL),
        .HIT_ROW   (HIT_ROW),
        .HIT_LE    (HIT_LE),
        .HIT_TE    (HIT_TE),
        .FREEZE    (FREEZE),
        .READ      (READ),
        .TOKEN     (TOKEN),
        .DATA      (DATA),
        .FIFO_COUNT(FIFO_COUNT),
        .LOST_CNT  (LOST_CNT),
        .ERR_CNT   (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] gray6(input logic [5:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [26:0] mk_word(input logic [5:0] c,
                                            input logic [8:0] r,
                                            input logic [5:0] l,
                                            input logic [5:0] t);
        return {c, gray6(t), gray6(l), r};
    endfunction

    function automatic logic tok_exp();
        return frz_m ? (frozen_m != 0) : (q.size() != 0);
    endfunction

    function automatic logic [26:0] model_pop();
        logic [26:0] w;
        w = '0;
        if (q.size() > 0) begin
            w = q.pop_front();
            if (frozen_m > 0)
                frozen_m--;
        end else if (err_m < 255) begin
            err_m++;
        end
        return w;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [5:0] c, input logic [8:0] r,
                        input logic [5:0] l, input logic [5:0] t);
        HIT_COL   = c;
        HIT_ROW   = r;
        HIT_LE    = l;
        HIT_TE    = t;
        HIT_WRITE = 1'b1;
        @(posedge CLK);
        #1 HIT_WRITE = 1'b0;
        if (q.size() < DEPTH)
            q.push_back(mk_word(c, r, l, t));
        else if (lost_m < 255)
            lost_m++;
    endtask

    task automatic push_rand();
        push(6'($urandom_range(63)), 9'($urandom_range(511)),
             6'($urandom_range(63)), 6'($urandom_range(63)));
    endtask

    task automatic set_freeze(input logic v);
        FREEZE = v;
        if (v && !frz_m)
            frozen_m = q.size();
        if (!v)
            frozen_m = 0;
        frz_m = v;
        @(posedge CLK);
        #1;
    endtask

    // rt >= 0 re-raises READ that many bits into the word
    task automatic read_word(input string tag, input int rt,
                             output logic [26:0] got);
        logic [26:0] exp;
        exp = model_pop();
        got = '0;
        READ = 1'b1;
        @(posedge CLK);
        #1 READ = 1'b0;
        for (int i = 0; i < 27; i++) begin
            @(negedge CLK);
            got = {got[25:0], DATA};
            if (i == rt) READ = 1'b1;
            if (i == rt + 1) READ = 1'b0;
        end
        if (rt >= 0 && err_m < 255)
            err_m++;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic read_two();
        logic [26:0] e1;
        logic [26:0] e2;
        logic [53:0] got;
        e1 = model_pop();
        e2 = model_pop();
        got = '0;
        READ = 1'b1;
        @(posedge CLK);
        #1 READ = 1'b0;
        for (int i = 0; i < 54; i++) begin
            @(negedge CLK);
            got = {got[52:0], DATA};
            if (i == 26) READ = 1'b1;
            if (i == 27) READ = 1'b0;
        end
        check("b2b_word1", 32'(got[53:27]), 32'(e1));
        check("b2b_word2", 32'(got[26:0]), 32'(e2));
    endtask

    initial begin
        logic [26:0] got;
        logic [26:0] exp;
        logic [5:0]  c;
        logic [8:0]  r;
        logic [5:0]  l;
        logic [5:0]  t;

        checks = 0;
        failures = 0;
        lost_m = 0;
        err_m = 0;
        frozen_m = 0;
        frz_m = 0;
        RST_N = 1'b0;
        HIT_WRITE = 1'b0;
        HIT_COL = '0;
        HIT_ROW = '0;
        HIT_LE = '0;
        HIT_TE = '0;
        FREEZE = 1'b0;
        READ = 1'b0;

        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_token", 32'(TOKEN), 0);
        check("rst_data", 32'(DATA), 0);
        check("rst_count", 32'(FIFO_COUNT), 0);
        check("rst_lost", 32'(LOST_CNT), 0);
        check("rst_err", 32'(ERR_CNT), 0);

        push(6'd5, 9'd300, 6'd10, 6'd13);
        @(posedge CLK);
        @(negedge CLK);
        check("single_token", 32'(TOKEN), 1);
        check("single_count", 32'(FIFO_COUNT), 1);
        set_freeze(1'b1);
        read_word("single_word", -1, got);
        check("single_literal", 32'(got),
              32'(27'b000101_001011_001111_100101100));
        idle(2);
        check("single_token_off", 32'(TOKEN), 0);
        check("single_data_idle", 32'(DATA), 0);
        set_freeze(1'b0);

        repeat (3) push_rand();
        set_freeze(1'b1);
        repeat (2) push_rand();
        for (int k = 0; k < 3; k++) begin
            read_word("frz_word", -1, got);
            idle(2);
        end
        check("frz_token_off", 32'(TOKEN), 32'(tok_exp()));
        check("frz_token_lit", 32'(TOKEN), 0);
        check("frz_count", 32'(FIFO_COUNT), 2);
        set_freeze(1'b0);
        idle(2);
        check("unfrz_token", 32'(TOKEN), 1);
        repeat (2) read_word("frz_drain", -1, got);

        idle(1);
        read_word("empty_word", -1, got);
        idle(1);
        check("empty_err", 32'(ERR_CNT), 32'(err_m));
        check("empty_err_lit", 32'(ERR_CNT), 1);

        push_rand();
        read_word("retrig_word", 10, got);
        idle(1);
        check("retrig_err", 32'(ERR_CNT), 32'(err_m));

        repeat (2) push_rand();
        idle(1);
        read_two();
        idle(2);
        check("b2b_count", 32'(FIFO_COUNT), 0);

        repeat (20) push_rand();
        idle(1);
        check("ovf_count", 32'(FIFO_COUNT), 16);
        check("ovf_lost", 32'(LOST_CNT), 4);
        check("ovf_lost_m", 32'(LOST_CNT), 32'(lost_m));

        c = 6'($urandom_range(63));
        r = 9'($urandom_range(511));
        l = 6'($urandom_range(63));
        t = 6'($urandom_range(63));
        HIT_COL = c;
        HIT_ROW = r;
        HIT_LE = l;
        HIT_TE = t;
        HIT_WRITE = 1'b1;
        READ = 1'b1;
        FREEZE = 1'b1;
        @(posedge CLK);
        #1;
        HIT_WRITE = 1'b0;
        READ = 1'b0;
        exp = q.pop_front();
        q.push_back(mk_word(c, r, l, t));
        frz_m = 1;
        frozen_m = q.size();
        got = '0;
        for (int i = 0; i < 27; i++) begin
            @(negedge CLK);
            got = {got[25:0], DATA};
        end
        check("sim_word", 32'(got), 32'(exp));
        idle(1);
        check("sim_count", 32'(FIFO_COUNT), 16);
        check("sim_token", 32'(TOKEN), 32'(tok_exp()));
        check("sim_lost", 32'(LOST_CNT), 4);
        set_freeze(1'b0);
        for (int k = 0; k < 16; k++)
            read_word("ovf_drain", -1, got);
        idle(2);
        check("drain_count", 32'(FIFO_COUNT), 0);
        check("drain_token", 32'(TOKEN), 0);

        repeat (16 + 256) push_rand();
        idle(1);
        check("sat_lost", 32'(LOST_CNT), 255);
        check("sat_lost_m", 32'(LOST_CNT), 32'(lost_m));
        check("sat_count", 32'(FIFO_COUNT), 16);

        READ = 1'b1;
        @(posedge CLK);
        #1 READ = 1'b0;
        for (int i = 0; i < 14; i++)
            @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mrst_data", 32'(DATA), 0);
        check("mrst_count", 32'(FIFO_COUNT), 0);
        check("mrst_token", 32'(TOKEN), 0);
        check("mrst_lost", 32'(LOST_CNT), 0);
        check("mrst_err", 32'(ERR_CNT), 0);
        RST_N = 1'b1;
        q.delete();
        lost_m = 0;
        err_m = 0;
        frozen_m = 0;
        frz_m = 0;
        idle(2);

        push_rand();
        read_word("post_rst_word", -1, got);
        idle(2);
        check("post_rst_count", 32'(FIFO_COUNT), 0);
        check("post_rst_err", 32'(ERR_CNT), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
